// File: rtl/student_tlul_arb_pkg.sv
// student_tlul_arb_pkg: arbiter FSM states and grant index width helper.
package student_tlul_arb_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;
   function automatic int grant_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/tlul_pkg.sv
// tlul_pkg: minimal TL-UL channel structs shared by hosts, devices and interconnect.
package tlul_pkg;
   typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
   typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;
   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

// File: rtl/student_rr_arbiter.sv
// student_rr_arbiter: picks the first requester at or after ptr; with STUDENT_TLUL_ARB_RR_EN
// undefined ptr stays 0 and this is a lowest-index priority encoder.
module student_rr_arbiter
   import student_tlul_arb_pkg::*;
#(
   parameter int NUM = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM-1:0]           req,
   input  logic                     take,
   output logic [grant_w(NUM)-1:0]  winner,
   output logic                     any
);
   localparam int GW = grant_w(NUM);
   logic [GW-1:0]    ptr;
   logic [2*NUM-1:0] rot;
   assign rot = {req, req} >> ptr;
   assign any = |req;
   // scan downwards so the smallest offset from ptr is the last (winning) assignment
   always_comb begin
      winner = '0;
      for (int i = NUM - 1; i >= 0; i--)
         if (rot[i]) winner = GW'((int'(ptr) + i >= NUM) ? int'(ptr) + i - NUM : int'(ptr) + i);
   end
`ifdef STUDENT_TLUL_ARB_RR_EN
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) ptr <= '0;
      else if (take) ptr <= (int'(winner) == NUM - 1) ? '0 : winner + 1'b1;
`else
   logic unused;
   assign ptr = '0;
   assign unused = clk_i ^ rst_ni ^ take;
`endif
endmodule

// File: rtl/student_tlul_arb.sv
// student_tlul_arb: N:1 TL-UL arbiter, one outstanding transaction, grant held until D accepted.
// Round-robin when STUDENT_TLUL_ARB_RR_EN is defined, fixed lowest-index priority otherwise.
module student_tlul_arb
   import tlul_pkg::*;
   import student_tlul_arb_pkg::*;
#(
   parameter int NUM = 2
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  tl_h2d_t tl_host_i [NUM],
   output tl_d2h_t tl_host_o [NUM],
   output tl_h2d_t tl_device_o,
   input  tl_d2h_t tl_device_i
);
   localparam int GW = grant_w(NUM);
   arb_state_e     state;
   logic [GW-1:0]  grant, winner;
   logic [NUM-1:0] req;
   logic           any, a_hs, d_hs;
   tl_h2d_t        sel;
   always_comb begin
      for (int k = 0; k < NUM; k++) req[k] = tl_host_i[k].a_valid;
   end
   student_rr_arbiter #(.NUM(NUM)) u_arb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req   (req),
      .take  (state == IDLE && any),
      .winner(winner),
      .any   (any)
   );
   assign sel  = tl_host_i[grant];
   assign a_hs = tl_device_o.a_valid & tl_device_i.a_ready;
   assign d_hs = tl_device_o.d_ready & tl_device_i.d_valid;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state <= IDLE;
         grant <= '0;
      end else begin
         case (state)
            IDLE: if (any) begin
               state <= ADDR;
               grant <= winner;
            end
            ADDR: state <= d_hs ? IDLE : (a_hs ? DATA : ADDR);
            default: state <= d_hs ? IDLE : DATA;
         endcase
      end
   // D fields also pass in ADDR so a same-cycle response is not lost to the host
   always_comb begin
      tl_device_o = sel;
      tl_device_o.a_valid = (state == ADDR) & sel.a_valid;
      tl_device_o.d_ready = (state != IDLE) & sel.d_ready;
      for (int k = 0; k < NUM; k++) tl_host_o[k] = '0;
      if (state != IDLE) begin
         tl_host_o[grant] = tl_device_i;
         tl_host_o[grant].a_ready = (state == ADDR) & tl_device_i.a_ready;
      end
   end
endmodule

// File: tb/tb_student_tlul_arb.sv
// tb_student_tlul_arb: scoreboard bench for the TL-UL arbiter (NUM=2 and NUM=3 instances).
// Expected grant orders follow STUDENT_TLUL_ARB_RR_EN.
module tb_student_tlul_arb;
   import tlul_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   int total = 0, bad = 0, cyc = 0, viol1 = 0;
   int last_d_cyc [2];
   tl_h2d_t h2 [2], h3 [3], dev_req, dev3_req;
   tl_d2h_t o2 [2], o3 [3], dev_rsp, dev3_rsp;
   logic [7:0] exp_q [$], obs_q [$], exp3_q [$], obs3_q [$];
   int av1_q [$];

   student_tlul_arb #(.NUM(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tl_host_i(h2), .tl_host_o(o2),
      .tl_device_o(dev_req), .tl_device_i(dev_rsp)
   );
   student_tlul_arb #(.NUM(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .tl_host_i(h3), .tl_host_o(o3),
      .tl_device_o(dev3_req), .tl_device_i(dev3_rsp)
   );

   // zero-wait word memory behind the 2-host arbiter
   logic dev_ar = 1'b1, err_inj = 1'b0;
   logic d_pend, d_err, d_rd;
   logic [7:0] d_src;
   logic [31:0] d_dat;
   logic [31:0] mem [16];
   always_comb begin
      dev_rsp = '0;
      dev_rsp.a_ready  = dev_ar;
      dev_rsp.d_valid  = d_pend;
      dev_rsp.d_opcode = d_rd ? AccessAckData : AccessAck;
      dev_rsp.d_size   = 2'd2;
      dev_rsp.d_source = d_src;
      dev_rsp.d_data   = d_dat;
      dev_rsp.d_error  = d_err;
   end
   always @(posedge clk or negedge rst_n)
      if (!rst_n) d_pend <= 1'b0;
      else if (dev_req.a_valid && dev_ar) begin
         d_pend <= 1'b1;
         d_src  <= dev_req.a_source;
         d_err  <= err_inj;
         d_rd   <= dev_req.a_opcode == Get;
         d_dat  <= (dev_req.a_opcode == Get) ? mem[dev_req.a_address[5:2]] : '0;
         if (dev_req.a_opcode != Get) mem[dev_req.a_address[5:2]] <= dev_req.a_data;
      end else if (d_pend && dev_req.d_ready) d_pend <= 1'b0;

   // always-ready acknowledger behind the 3-host arbiter
   logic d3_pend;
   logic [7:0] d3_src;
   always_comb begin
      dev3_rsp = '0;
      dev3_rsp.a_ready  = 1'b1;
      dev3_rsp.d_valid  = d3_pend;
      dev3_rsp.d_source = d3_src;
   end
   always @(posedge clk or negedge rst_n)
      if (!rst_n) d3_pend <= 1'b0;
      else if (dev3_req.a_valid) begin
         d3_pend <= 1'b1;
         d3_src  <= dev3_req.a_source;
      end else if (d3_pend && dev3_req.d_ready) d3_pend <= 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (dev_req.a_valid && dev_rsp.a_ready) obs_q.push_back(dev_req.a_source);
      if (dev3_req.a_valid) obs3_q.push_back(dev3_req.a_source);
      if (dev_req.a_valid && dev_req.a_source == 8'd1) av1_q.push_back(cyc);
      if (o2[1].a_ready || o2[1].d_valid) viol1 <= viol1 + 1;
   end

   task automatic host_txn(input int k, input bit wr, input logic [31:0] adr, input logic [31:0] dat,
                           input int dly, output logic [31:0] rd, output logic err);
      int n = 0;
      h2[k].a_valid   = 1'b1;
      h2[k].a_opcode  = wr ? PutFullData : Get;
      h2[k].a_address = adr;
      h2[k].a_data    = dat;
      h2[k].a_source  = 8'(k);
      h2[k].a_mask    = 4'hf;
      h2[k].a_size    = 2'd2;
      h2[k].d_ready   = dly == 0;
      do begin @(negedge clk); n++; end while (!o2[k].a_ready && n < 100);
      total++;
      if (n >= 100) begin bad++; $display("FAIL a_timeout host%0d: a_ready=%b required 1", k, o2[k].a_ready); end
      @(posedge clk); #1 h2[k].a_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!o2[k].d_valid && n < 100);
      total++;
      if (n >= 100) begin bad++; $display("FAIL d_timeout host%0d: d_valid=%b required 1", k, o2[k].d_valid); end
      if (dly > 0) begin
         repeat (dly) @(posedge clk);
         #1 h2[k].d_ready = 1'b1;
         @(negedge clk);
      end
      rd = o2[k].d_data;
      err = o2[k].d_error;
      last_d_cyc[k] = cyc;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      h2[0].a_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (o2[0] !== '0) begin bad++; $display("FAIL rst_host0: got %h required 0", o2[0]); end
      total++; if (o2[1] !== '0) begin bad++; $display("FAIL rst_host1: got %h required 0", o2[1]); end
      total++; if (dev_req.a_valid !== 1'b0 || dev_req.d_ready !== 1'b0)
         begin bad++; $display("FAIL rst_dev: a_valid=%b d_ready=%b required 0 0", dev_req.a_valid, dev_req.d_ready); end
      total++; if (dev3_req.a_valid !== 1'b0) begin bad++; $display("FAIL rst_dev3: a_valid=%b required 0", dev3_req.a_valid); end
      h2[0].a_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (o2[0] !== '0 || dev_req.a_valid !== 1'b0)
         begin bad++; $display("FAIL idle_after_rst: host0=%h dev_a_valid=%b required 0 0", o2[0], dev_req.a_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      logic [31:0] rd;
      logic er;
      logic [7:0] e, g;
      int v0 = viol1;
      exp_q.push_back(8'd0); exp_q.push_back(8'd0);
      host_txn(0, 1'b1, 32'h4, 32'h12345678, 0, rd, er);
      host_txn(0, 1'b0, 32'h4, 32'h0, 0, rd, er);
      total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL single_rdata: got %h required 12345678", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL single_err: got %b required 0", er); end
      total++; if (viol1 - v0 !== 0) begin bad++; $display("FAIL host1_quiet: got %0d cycles active required 0", viol1 - v0); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL single_order: got none required %0d", e); end
         else begin g = obs_q.pop_front(); if (g !== e) begin bad++; $display("FAIL single_order: got %0d required %0d", g, e); end end
      end
   endtask

   task automatic test_simultaneous;
      logic [31:0] r0, r1;
      logic e0, e1;
      logic [7:0] e, g;
`ifdef STUDENT_TLUL_ARB_RR_EN
      for (int i = 0; i < 4; i++) begin exp_q.push_back(8'd0); exp_q.push_back(8'd1); end
`else
      for (int i = 0; i < 4; i++) exp_q.push_back(8'd0);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'd1);
`endif
      fork
         for (int i = 0; i < 4; i++) host_txn(0, 1'b1, 32'(4 * i), 32'(i), 0, r0, e0);
         for (int i = 0; i < 4; i++) host_txn(1, 1'b1, 32'(32 + 4 * i), 32'(16 + i), 0, r1, e1);
      join
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL simul_order: got none required %0d", e); end
         else begin g = obs_q.pop_front(); if (g !== e) begin bad++; $display("FAIL simul_order: got %0d required %0d", g, e); end end
      end
      total++; if (obs_q.size() != 0) begin bad++; $display("FAIL simul_extra: got %0d extra grants required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_backpressure;
      logic [31:0] r0, r1;
      logic e0, e1;
      logic [7:0] e, g;
      av1_q.delete();
      exp_q.push_back(8'd0); exp_q.push_back(8'd1);
      fork
         host_txn(0, 1'b1, 32'h10, 32'h11, 5, r0, e0);
         begin repeat (3) @(posedge clk); #1 host_txn(1, 1'b1, 32'h14, 32'h22, 0, r1, e1); end
      join
      total++;
      if (av1_q.size() == 0) begin bad++; $display("FAIL bp_host1_grant: got none required cycle %0d", last_d_cyc[0] + 2); end
      else if (av1_q[0] != last_d_cyc[0] + 2)
         begin bad++; $display("FAIL bp_host1_grant: got cycle %0d required %0d", av1_q[0], last_d_cyc[0] + 2); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL bp_order: got none required %0d", e); end
         else begin g = obs_q.pop_front(); if (g !== e) begin bad++; $display("FAIL bp_order: got %0d required %0d", g, e); end end
      end
   endtask

   task automatic test_latency;
      logic [31:0] rd;
      logic er;
      logic [7:0] e, g;
      int n = 0;
      exp_q.push_back(8'd1); exp_q.push_back(8'd1);
      host_txn(1, 1'b1, 32'h8, 32'hCAFEF00D, 0, rd, er);
      err_inj = 1'b1;
      h2[1].a_opcode  = Get;
      h2[1].a_address = 32'h8;
      h2[1].d_ready   = 1'b1;
      h2[1].a_valid   = 1'b1;
      @(negedge clk);
      total++; if (dev_req.a_valid !== 1'b0) begin bad++; $display("FAIL lat_t: dev a_valid=%b required 0", dev_req.a_valid); end
      @(negedge clk);
      total++; if (dev_req.a_valid !== 1'b1 || dev_req.a_source !== 8'd1)
         begin bad++; $display("FAIL lat_t1: dev a_valid=%b source=%0d required 1 1", dev_req.a_valid, dev_req.a_source); end
      @(posedge clk); #1 h2[1].a_valid = 1'b0;
      do begin @(negedge clk); n++; end while (!dev_rsp.d_valid && n < 50);
      total++; if (o2[1].d_valid !== 1'b1 || o2[1].d_data !== 32'hCAFEF00D)
         begin bad++; $display("FAIL lat_resp: d_valid=%b d_data=%h required 1 cafef00d", o2[1].d_valid, o2[1].d_data); end
      total++; if (o2[1].d_error !== 1'b1) begin bad++; $display("FAIL lat_err: got %b required 1", o2[1].d_error); end
      total++; if (o2[0] !== '0) begin bad++; $display("FAIL lat_host0_zero: got %h required 0", o2[0]); end
      @(posedge clk); #1 err_inj = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL lat_order: got none required %0d", e); end
         else begin g = obs_q.pop_front(); if (g !== e) begin bad++; $display("FAIL lat_order: got %0d required %0d", g, e); end end
      end
   endtask

   task automatic test_reset_in_data;
      logic [31:0] r0, r1;
      logic e0, e1;
      logic [7:0] e, g;
      int n = 0;
      exp_q.push_back(8'd0);
      h2[0].a_opcode  = PutFullData;
      h2[0].a_address = 32'h20;
      h2[0].a_source  = 8'd0;
      h2[0].d_ready   = 1'b0;
      h2[0].a_valid   = 1'b1;
      do begin @(negedge clk); n++; end while (!(dev_req.a_valid && dev_rsp.a_ready) && n < 50);
      @(posedge clk); #1 h2[0].a_valid = 1'b0;
      @(negedge clk);
      total++; if (o2[0].d_valid !== 1'b1) begin bad++; $display("FAIL rd_in_data: d_valid=%b required 1", o2[0].d_valid); end
      rst_n = 1'b0;
      #1;
      total++; if (o2[0] !== '0 || o2[1] !== '0)
         begin bad++; $display("FAIL rd_hosts_zero: host0=%h host1=%h required 0 0", o2[0], o2[1]); end
      total++; if (dev_req.a_valid !== 1'b0 || dev_req.d_ready !== 1'b0)
         begin bad++; $display("FAIL rd_dev_zero: a_valid=%b d_ready=%b required 0 0", dev_req.a_valid, dev_req.d_ready); end
      @(posedge clk); #1 rst_n = 1'b1;
      h2[0].d_ready = 1'b1;
      exp_q.push_back(8'd0); exp_q.push_back(8'd1);
      fork
         host_txn(0, 1'b1, 32'h24, 32'h1, 0, r0, e0);
         host_txn(1, 1'b1, 32'h28, 32'h2, 0, r1, e1);
      join
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (obs_q.size() == 0) begin bad++; $display("FAIL rd_order: got none required %0d", e); end
         else begin g = obs_q.pop_front(); if (g !== e) begin bad++; $display("FAIL rd_order: got %0d required %0d", g, e); end end
      end
   endtask

   task automatic test_three_host;
      int n = 0;
      logic [7:0] e;
      obs3_q.delete();
      for (int i = 0; i < 6; i++) begin
`ifdef STUDENT_TLUL_ARB_RR_EN
         exp3_q.push_back(8'(i % 3));
`else
         exp3_q.push_back(8'd0);
`endif
      end
      for (int k = 0; k < 3; k++) begin
         h3[k].a_opcode = Get;
         h3[k].a_source = 8'(k);
         h3[k].d_ready  = 1'b1;
         h3[k].a_valid  = 1'b1;
      end
      while (obs3_q.size() < 6 && n < 200) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) h3[k].a_valid = 1'b0;
      total++; if (obs3_q.size() < 6) begin bad++; $display("FAIL fair_count: got %0d grants required 6", obs3_q.size()); end
      for (int i = 0; i < 6; i++) begin
         e = exp3_q.pop_front();
         if (i < obs3_q.size()) begin
            total++;
            if (obs3_q[i] !== e) begin bad++; $display("FAIL fair_order[%0d]: got %0d required %0d", i, obs3_q[i], e); end
         end
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin h2[k] = '0; h2[k].d_ready = 1'b1; end
      for (int k = 0; k < 3; k++) h3[k] = '0;
      test_reset;
      test_single;
      test_simultaneous;
      test_backpressure;
      test_latency;
      test_reset_in_data;
      test_three_host;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t required finish", $time);
      $fatal(1);
   end
endmodule
